multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 run  input  1  level enable; 1 = keep fetching instructions.
REQ-004 op_in  input  6  opcode field of the instruction register.
REQ-005 func_in  input  6  function field of the instruction register.
REQ-006 zero_in  input  1  ALU zero flag for the BEQ compare.
REQ-007 mem_ready  input  1  memory access complete this cycle.
REQ-008 pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg  output  1 each  datapath strobes/selects.
REQ-009 alu_src_a  output  1  0 = PC, 1 = register A.
REQ-010 alu_src_b  output  2  0 = register B, 1 = constant 4, 2 = sign-extended immediate, 3 = shifted immediate.
REQ-011 alu_cntrl  output  4  0000 ADD, 0001 SUB, 0010 AND, 0100 SLT, 0101 OR.
REQ-012 pc_src  output  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump target.
REQ-013 state  output  4  current state encoding.
REQ-014 illegal  output  1  one-cycle pulse on an undecodable instruction.
REQ-015 retired  output  16  count of completed instructions.

Function
REQ-016 States SHALL be IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12.
REQ-017 Outputs SHALL be decoded combinationally from state (plus zero_in, mem_ready); any strobe not listed for a state SHALL be 0.
REQ-018 IDLE: all outputs 0; go to FETCH when run=1.
REQ-019 FETCH: mem_read=1, alu_src_a=0, alu_src_b=1, ADD, pc_src=0; ir_write=pc_write=1 in the completing cycle; then DECODE.
REQ-020 DECODE: alu_src_a=0, alu_src_b=3, ADD (branch target); next state by opcode: 100011/101011 -> MEM_ADDR, 000000 -> R_EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDI_EXEC.
REQ-021 DECODE with op=000000, func=000000 (NOP) SHALL complete without register write.
REQ-022 DECODE with any other opcode, or op=000000 with func not in {100000, 100010, 100100, 100101, 101010, 000000}, SHALL pulse illegal and complete.
REQ-023 MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD; LW -> MEM_RD, SW -> MEM_WR.
REQ-024 MEM_RD: mem_read=1; on completion -> MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; completes.
REQ-025 MEM_WR: mem_write=1; completes on its completing cycle.
REQ-026 R_EXEC: alu_src_a=1, alu_src_b=0, alu_cntrl per func (100000 ADD, 100010 SUB, 100100 AND, 101010 SLT, 100101 OR) -> R_WB. R_WB: reg_write=1, reg_dst=1; completes.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1, pc_write=zero_in; completes.
REQ-028 JUMP: pc_src=2, pc_write=1; completes. ADDI_EXEC: alu_src_a=1, alu_src_b=2, ADD -> ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0; completes.
REQ-029 On completion, retired SHALL increment by 1 (wrap 0xFFFF -> 0x0000, illegal and NOP included), and next state SHALL be FETCH if run=1, else IDLE.
REQ-030 run deasserted mid-instruction SHALL NOT abort it; it takes effect only at completion.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE and retired=0, so all outputs read 0, irrespective of clk or the state in progress.
REQ-032 The first state change after rst_n rises SHALL occur on a rising clk edge with run=1.

Configuration
REQ-033 With MEM_WAIT_EN defined, FETCH, MEM_RD and MEM_WR SHALL hold, strobes asserted (ir_write/pc_write suppressed), until mem_ready=1; the mem_ready=1 cycle is the completing cycle.
REQ-034 Without MEM_WAIT_EN, mem_ready SHALL be ignored and every memory state SHALL complete in one cycle.

Verification
REQ-035 Reset, run=1, op=100011 (LW), no wait -> states 1,2,3,4,5,1; reg_write=mem_to_reg=1 in state 5; retired=1.
REQ-036 op=000000 func=101010 -> alu_cntrl=0100 in R_EXEC; reg_write=reg_dst=1 in R_WB; 4 cycles FETCH to FETCH.
REQ-037 BEQ with zero_in=0 then zero_in=1 -> pc_write 0 then 1 in BRANCH, pc_src=1 both times.
REQ-038 MEM_WAIT_EN, SW with mem_ready low 3 cycles -> mem_write=1 for 4 cycles in MEM_WR, then FETCH.
REQ-039 op=111111 -> illegal=1 for exactly one cycle in DECODE; retired increments; run=0 then -> IDLE.
REQ-040 rst_n low mid-MEM_RD -> state=0, retired=0, all strobes 0 before the next clk edge.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Handshake/strobe bundle between the multicycle controller and its datapath.
// The slave modport is the controller; the master modport is the datapath side.
interface multicycle_controller_if;
  logic        run;
  logic [5:0]  op_in;
  logic [5:0]  func_in;
  logic        zero_in;
  logic        mem_ready;

  logic        pc_write;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_cntrl;
  logic [1:0]  pc_src;
  logic [3:0]  state;
  logic        illegal;
  logic [15:0] retired;

  modport master (
    output run, op_in, func_in, zero_in, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_cntrl, pc_src, state, illegal, retired
  );

  modport slave (
    input  run, op_in, func_in, zero_in, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_cntrl, pc_src, state, illegal, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM with a retired-instruction counter.
// Define MEM_WAIT_EN to make FETCH/MEM_RD/MEM_WR wait for mem_ready.
module multicycle_controller (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.slave  bus
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] FETCH     = 4'd1;
  localparam logic [3:0] DECODE    = 4'd2;
  localparam logic [3:0] MEM_ADDR  = 4'd3;
  localparam logic [3:0] MEM_RD    = 4'd4;
  localparam logic [3:0] MEM_WB    = 4'd5;
  localparam logic [3:0] MEM_WR    = 4'd6;
  localparam logic [3:0] R_EXEC    = 4'd7;
  localparam logic [3:0] R_WB      = 4'd8;
  localparam logic [3:0] BRANCH    = 4'd9;
  localparam logic [3:0] JUMP      = 4'd10;
  localparam logic [3:0] ADDI_EXEC = 4'd11;
  localparam logic [3:0] ADDI_WB   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_NOP = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;

  logic [3:0]  state_q, state_d;
  logic [15:0] retired_q;
  logic        mem_done;
  logic        complete;
  logic        is_nop;
  logic        is_illegal;
  logic [3:0]  r_alu;

`ifdef MEM_WAIT_EN
  assign mem_done = bus.mem_ready;
`else
  // Memory is single-cycle in this build; mem_ready is intentionally unused.
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_done         = 1'b1;
`endif

  // Instruction classification from the instruction register fields.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    is_nop     = 1'b0;
    is_illegal = 1'b0;
    r_alu      = ALU_ADD;
    case (bus.op_in)
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ;
      OP_RTYPE: begin
        case (bus.func_in)
          FN_NOP: is_nop = 1'b1;
          FN_ADD: r_alu  = ALU_ADD;
          FN_SUB: r_alu  = ALU_SUB;
          FN_AND: r_alu  = ALU_AND;
          FN_OR:  r_alu  = ALU_OR;
          FN_SLT: r_alu  = ALU_SLT;
          default: is_illegal = 1'b1;
        endcase
      end
      default: is_illegal = 1'b1;
    endcase
  end

  // Next state; NOP and illegal instructions retire straight out of DECODE.
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    case (state_q)
      IDLE:     if (bus.run) state_d = FETCH;
      FETCH:    if (mem_done) state_d = DECODE;
      DECODE: begin
        if (is_nop || is_illegal) begin
          complete = 1'b1;
        end else begin
          case (bus.op_in)
            OP_LW, OP_SW: state_d = MEM_ADDR;
            OP_RTYPE:     state_d = R_EXEC;
            OP_BEQ:       state_d = BRANCH;
            OP_J:         state_d = JUMP;
            OP_ADDI:      state_d = ADDI_EXEC;
            default:      complete = 1'b1;
          endcase
        end
      end
      MEM_ADDR:  state_d = (bus.op_in == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:    if (mem_done) state_d = MEM_WB;
      MEM_WR:    complete = mem_done;
      R_EXEC:    state_d = R_WB;
      ADDI_EXEC: state_d = ADDI_WB;
      MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: complete = 1'b1;
      default:   state_d = IDLE;
    endcase
    if (complete) state_d = bus.run ? FETCH : IDLE;
  end

  // Datapath strobes are a pure decode of the current state.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'd0;
    bus.alu_cntrl  = ALU_ADD;
    bus.pc_src     = 2'd0;
    bus.illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'd1;
        bus.ir_write  = mem_done;
        bus.pc_write  = mem_done;
      end
      DECODE: begin
        bus.alu_src_b = 2'd3;
        bus.illegal   = is_illegal;
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd2;
      end
      MEM_RD: bus.mem_read = 1'b1;
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      MEM_WR: bus.mem_write = 1'b1;
      R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_cntrl = r_alu;
      end
      R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_cntrl = ALU_SUB;
        bus.pc_src    = 2'd1;
        bus.pc_write  = bus.zero_in;
      end
      JUMP: begin
        bus.pc_src   = 2'd2;
        bus.pc_write = 1'b1;
      end
      ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd2;
      end
      ADDI_WB: bus.reg_write = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      retired_q <= 16'd0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
      if (complete) retired_q <= retired_q + 16'd1;
    end
  end

  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected per-cycle output
// snapshots are queued as stimulus is driven and compared at each negedge.
module tb_multicycle_controller;

  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,
                         S_MADDR = 4'd3, S_MRD = 4'd4,    S_MWB = 4'd5,
                         S_MWR = 4'd6,   S_REXEC = 4'd7,  S_RWB = 4'd8,
                         S_BR = 4'd9,    S_JMP = 4'd10,   S_AEXEC = 4'd11,
                         S_AWB = 4'd12;

  typedef struct packed {
    logic [3:0]  state;
    logic        pc_write;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_cntrl;
    logic [1:0]  pc_src;
    logic        illegal;
    logic [15:0] retired;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  out_t        sb[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] ret_cnt = 16'd0;

  // Expected outputs of each state for a plain (non-stalled, not-taken) cycle.
  function automatic out_t nominal(input logic [3:0] s);
    out_t v = '0;
    v.state   = s;
    v.retired = ret_cnt;
    case (s)
      S_FETCH:  begin v.mem_read = 1; v.alu_src_b = 2'd1; v.ir_write = 1; v.pc_write = 1; end
      S_DECODE: v.alu_src_b = 2'd3;
      S_MADDR:  begin v.alu_src_a = 1; v.alu_src_b = 2'd2; end
      S_MRD:    v.mem_read = 1;
      S_MWB:    begin v.reg_write = 1; v.mem_to_reg = 1; end
      S_MWR:    v.mem_write = 1;
      S_REXEC:  v.alu_src_a = 1;
      S_RWB:    begin v.reg_write = 1; v.reg_dst = 1; end
      S_BR:     begin v.alu_src_a = 1; v.alu_cntrl = 4'b0001; v.pc_src = 2'd1; end
      S_JMP:    begin v.pc_src = 2'd2; v.pc_write = 1; end
      S_AEXEC:  begin v.alu_src_a = 1; v.alu_src_b = 2'd2; end
      S_AWB:    v.reg_write = 1;
      default:  ;
    endcase
    return v;
  endfunction

  function automatic out_t sample();
    out_t v;
    v.state      = bus.state;
    v.pc_write   = bus.pc_write;
    v.ir_write   = bus.ir_write;
    v.mem_read   = bus.mem_read;
    v.mem_write  = bus.mem_write;
    v.reg_write  = bus.reg_write;
    v.reg_dst    = bus.reg_dst;
    v.mem_to_reg = bus.mem_to_reg;
    v.alu_src_a  = bus.alu_src_a;
    v.alu_src_b  = bus.alu_src_b;
    v.alu_cntrl  = bus.alu_cntrl;
    v.pc_src     = bus.pc_src;
    v.illegal    = bus.illegal;
    v.retired    = bus.retired;
    return v;
  endfunction

  function automatic void push(input out_t v);
    sb.push_back(v);
  endfunction

  // Pushes the completing cycle of an instruction; later snapshots see the bumped count.
  function automatic void push_done(input out_t v);
    sb.push_back(v);
    ret_cnt = ret_cnt + 16'd1;
  endfunction

  // One snapshot per cycle, bounded by the queue length.
  task automatic drain(input string tag);
    out_t got, exp;
    while (sb.size() > 0) begin
      @(negedge clk);
      exp = sb.pop_front();
      got = sample();
      n_total++;
      if (got !== exp)
        $display("FAIL %s: state=%0d got=%h expected=%h", tag, got.state, got, exp);
      else
        n_pass++;
    end
  endtask

  task automatic start_instr(input logic [5:0] op, input logic [5:0] func);
    @(posedge clk);
    #1;
    bus.op_in   = op;
    bus.func_in = func;
  endtask

  task automatic test_reset();
    bus.run = 0; bus.op_in = '0; bus.func_in = '0; bus.zero_in = 0; bus.mem_ready = 1;
    rst_n = 1;
    #2 rst_n = 0;
    #1;
    n_total++;
    if (bus.state !== S_IDLE) $display("FAIL reset_state: got %0d expected 0", bus.state);
    else n_pass++;
    n_total++;
    if (bus.retired !== 16'd0) $display("FAIL reset_retired: got %0d expected 0", bus.retired);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1;
    push(nominal(S_IDLE));
    push(nominal(S_IDLE));
    drain("idle_hold_run0");
    bus.run = 1;
  endtask

  task automatic test_lw();
    start_instr(6'b100011, 6'b000000);
    push(nominal(S_FETCH));
    push(nominal(S_DECODE));
    push(nominal(S_MADDR));
    push(nominal(S_MRD));
    push_done(nominal(S_MWB));
    drain("lw");
  endtask

  task automatic test_sw();
    start_instr(6'b101011, 6'b000000);
    push(nominal(S_FETCH));
    push(nominal(S_DECODE));
    push(nominal(S_MADDR));
    push_done(nominal(S_MWR));
    drain("sw");
  endtask

  task automatic test_r_type();
    logic [5:0] funcs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [3:0] ctl   [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b0100};
    out_t v;
    for (int i = 0; i < 5; i++) begin
      start_instr(6'b000000, funcs[i]);
      push(nominal(S_FETCH));
      push(nominal(S_DECODE));
      v = nominal(S_REXEC);
      v.alu_cntrl = ctl[i];
      push(v);
      push_done(nominal(S_RWB));
      drain("r_type");
    end
  endtask

  task automatic test_nop();
    start_instr(6'b000000, 6'b000000);
    push(nominal(S_FETCH));
    push_done(nominal(S_DECODE));
    drain("nop");
  endtask

  task automatic test_branch();
    out_t v;
    for (int z = 0; z < 2; z++) begin
      start_instr(6'b000100, 6'b000000);
      bus.zero_in = z[0];
      push(nominal(S_FETCH));
      push(nominal(S_DECODE));
      v = nominal(S_BR);
      v.pc_write = z[0];
      push_done(v);
      drain(z == 0 ? "beq_not_taken" : "beq_taken");
    end
    bus.zero_in = 0;
  endtask

  task automatic test_jump_addi();
    start_instr(6'b000010, 6'b000000);
    push(nominal(S_FETCH));
    push(nominal(S_DECODE));
    push_done(nominal(S_JMP));
    drain("jump");
    start_instr(6'b001000, 6'b000000);
    push(nominal(S_FETCH));
    push(nominal(S_DECODE));
    push(nominal(S_AEXEC));
    push_done(nominal(S_AWB));
    drain("addi");
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait();
    out_t v;
    start_instr(6'b101011, 6'b000000);
    bus.mem_ready = 0;
    v = nominal(S_FETCH);
    v.ir_write = 0;
    v.pc_write = 0;
    push(v);
    drain("fetch_stall");
    @(posedge clk);
    #1 bus.mem_ready = 1;
    push(nominal(S_FETCH));
    push(nominal(S_DECODE));
    push(nominal(S_MADDR));
    drain("sw_wait_pre");
    bus.mem_ready = 0;
    repeat (3) push(nominal(S_MWR));
    drain("sw_wait_hold");
    @(posedge clk);
    #1 bus.mem_ready = 1;
    push_done(nominal(S_MWR));
    drain("sw_wait_done");
  endtask
`else
  task automatic test_mem_wait();
    start_instr(6'b100011, 6'b000000);
    bus.mem_ready = 0;
    push(nominal(S_FETCH));
    push(nominal(S_DECODE));
    push(nominal(S_MADDR));
    push(nominal(S_MRD));
    push_done(nominal(S_MWB));
    drain("mem_ready_ignored");
    bus.mem_ready = 1;
  endtask
`endif

  task automatic test_illegal();
    out_t v;
    start_instr(6'b000000, 6'b111111);
    push(nominal(S_FETCH));
    v = nominal(S_DECODE);
    v.illegal = 1;
    push_done(v);
    drain("illegal_func");
    start_instr(6'b111111, 6'b000000);
    push(nominal(S_FETCH));
    drain("illegal_op_fetch");
    bus.run = 0;
    v = nominal(S_DECODE);
    v.illegal = 1;
    push_done(v);
    push(nominal(S_IDLE));
    push(nominal(S_IDLE));
    drain("illegal_op_to_idle");
    bus.run = 1;
  endtask

  task automatic test_async_reset();
    out_t got;
    start_instr(6'b100011, 6'b000000);
    push(nominal(S_FETCH));
    push(nominal(S_DECODE));
    push(nominal(S_MADDR));
    drain("lw_before_reset");
    @(posedge clk);
    #2;
    n_total++;
    if (bus.state !== S_MRD) $display("FAIL pre_reset_state: got %0d expected 4", bus.state);
    else n_pass++;
    rst_n = 0;
    #1;
    got = sample();
    n_total++;
    if (got !== out_t'(0)) $display("FAIL async_reset: got=%h expected=0", got);
    else n_pass++;
    ret_cnt = 16'd0;
    push(nominal(S_IDLE));
    drain("reset_held");
    rst_n = 1;
    bus.op_in = 6'b000010;
    push(nominal(S_FETCH));
    push(nominal(S_DECODE));
    push_done(nominal(S_JMP));
    push(nominal(S_FETCH));
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_r_type();
    test_nop();
    test_branch();
    test_jump_addi();
    test_mem_wait();
    test_illegal();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
